smi_mdio_master: RTL and testbench
==================================

// Module: smi_mdio_master
// PURPOSE
//   Clause-22 MDIO/MDC serial engine: turns a single-cycle read or write request into one
//   64-bit IEEE 802.3 management frame on mdc/mdio and returns read data.
//   Sits directly below smi_config-style PHY pollers; owns the mdc/mdio pins to the PHY.
// PARAMETERS
//   REF_CLK   50    clk frequency, MHz
//   MDC_CLK   500   target mdc frequency, kHz
//   HALF      derived = REF_CLK*1000/(2*MDC_CLK), truncated; clk cycles per mdc half-period (50 at defaults); must be >=2
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   mdc         out  1   management clock to PHY
//   mdio        inout 1  management data; driven only while oe, else 1'bz
//   phy_addr    in   5   PHY address, latched on request accept
//   reg_addr    in   5   register address, latched on request accept
//   write_req   in   1   1-cycle write request pulse
//   write_data  in   16  write payload, latched on accept
//   read_req    in   1   1-cycle read request pulse
//   read_data   out  16  last read result, held until the next read completes
//   data_valid  out  1   1-cycle pulse, read frame complete, read_data updated
//   done        out  1   1-cycle pulse, any frame complete
//   busy        out  1   high from accept until done (inclusive)
//   ta_err      out  1   1-cycle pulse with done: read turnaround not pulled low (no PHY)
// BEHAVIOUR
//   Reset: mdc=0, mdio released (oe=0), read_data=0, data_valid=done=busy=ta_err=0, state IDLE.
//   MDC gen: free-running counter 0..HALF-1; on HALF-1 mdc toggles and counter wraps.
//     fall_tick = cycle mdc goes 1->0; rise_tick = cycle mdc goes 0->1.
//   Accept: only in IDLE; write_req has priority over read_req if both high in the same cycle;
//     requests while busy are dropped (not queued). Accept latches addr/data, sets busy.
//   Frame, MSB first, bit index 0..63, each bit launched on fall_tick and held one full mdc period:
//     0-31 preamble 1s | 32-33 ST=01 | 34-35 OP: read 10, write 01 | 36-40 PHYAD | 41-45 REGAD
//     46-47 TA: write drives 1,0; read releases mdio | 48-63 DATA: write drives, read samples
//   States: IDLE -> ALIGN (wait next fall_tick) -> PRE (32 bits) -> HDR (14 bits) -> TA (2)
//     -> DAT (16) -> FIN -> IDLE. A 6-bit bit counter advances on each fall_tick.
//   oe: write frame drives bits 0-63; read frame drives bits 0-45, released from bit 46 onward.
//   Read sampling on rise_tick: TA bit 47 sample must be 0, otherwise ta_err;
//     data bits 48-63 shift into a 16-bit shift register, MSB first.
//   FIN: entered on the fall_tick ending bit 63. That cycle: oe=0, done=1; for a read also
//     data_valid=1 and read_data<=shift register (updated even when ta_err is set).
//     busy drops the next cycle; a new request is accepted from that cycle on.
//   read_data is stable from the data_valid cycle until the next data_valid; a caller may
//     sample it on or after done.
//   Latency: accept -> done = 64 mdc periods plus ALIGN wait (<=2*HALF clk);
//     6400..6500 clk at defaults.
//   mdc keeps toggling while idle; mdio is never driven in IDLE.
//   Async reset mid-frame: frame abandoned, mdio released immediately, no done pulse.
//     A later request starts a fresh frame, preamble included.
// TESTING
//   1 Write phy=1 reg=0 data=16'h1140 -> mdio bitstream 32x1,01,01,00001,00000,10,0001000101000000;
//     done one pulse; data_valid=0.
//   2 Read phy=1 reg=1; PHY model drives TA0=0 and 16'h796D -> data_valid and done same cycle,
//     read_data=16'h796D, ta_err=0; mdio Z from bit 46.
//   3 Read with no PHY (pull-up, mdio=1) -> read_data=16'hFFFF, ta_err=1 pulse with done.
//   4 read_req and write_req in the same cycle -> write frame (OP=01) only;
//     req pulses during busy -> ignored, exactly one done.
//   5 rst_n low at bit 40 of a write -> mdio Z and mdc 0 asynchronously, no done;
//     post-reset read completes normally.
//   6 Timing check at defaults: mdc period 100 clk, 50% duty;
//     mdio changes only within 1 clk after mdc falling edge.

Source files
------------

// File: rtl/smi_mdio_master.sv
// Clause-22 MDIO/MDC master: one 64-bit management frame per request, read data returned on completion.
module smi_mdio_master #(
    parameter int REF_CLK = 50,
    parameter int MDC_CLK = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mdc,
    inout  wire         mdio,
    input  logic [4:0]  phy_addr,
    input  logic [4:0]  reg_addr,
    input  logic        write_req,
    input  logic [15:0] write_data,
    input  logic        read_req,
    output logic [15:0] read_data,
    output logic        data_valid,
    output logic        done,
    output logic        busy,
    output logic        ta_err
);

    localparam int HALF = REF_CLK * 1000 / (2 * MDC_CLK);
    localparam int CW   = $clog2(HALF);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, ALIGN, PRE, HDR, TA, DAT, FIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_q, div_d;
    logic          mdc_q, mdc_d;
    logic [5:0]    bit_q, bit_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   hdr_q, hdr_d;
    logic          oe_q, oe_d;
    logic          mdo_q, mdo_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ta_bad_q, ta_bad_d;
    logic [1:0]    sync_q, sync_d;

    logic       tick, fall_tick, rise_tick, mdi;
    logic [5:0] nbit;

    assign mdio      = oe_q ? mdo_q : 1'bz;
    assign mdc       = mdc_q;
    assign read_data = rdata_q;
    assign mdi       = sync_q[1];

    always_comb begin
        tick      = (div_q == HALF_M1);
        fall_tick = tick & mdc_q;
        rise_tick = tick & ~mdc_q;
        div_d     = tick ? '0 : div_q + 1'b1;
        mdc_d     = tick ? ~mdc_q : mdc_q;
        sync_d    = {sync_q[0], mdio};
        nbit      = bit_q + 6'd1;

        state_d    = state_q;
        bit_d      = bit_q;
        is_wr_d    = is_wr_q;
        hdr_d      = hdr_q;
        oe_d       = oe_q;
        mdo_d      = mdo_q;
        shift_d    = shift_q;
        rdata_d    = rdata_q;
        ta_bad_d   = ta_bad_q;

        done       = (state_q == FIN);
        data_valid = (state_q == FIN) & ~is_wr_q;
        ta_err     = (state_q == FIN) & ~is_wr_q & ta_bad_q;
        busy       = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (write_req || read_req) begin
                    state_d  = ALIGN;
                    is_wr_d  = write_req;
                    ta_bad_d = 1'b0;
                    // Bits 32..63 of the frame; a read's TA/data slots are never driven.
                    hdr_d    = {2'b01, (write_req ? 2'b01 : 2'b10), phy_addr, reg_addr,
                                2'b10, (write_req ? write_data : 16'h0000)};
                end
            end
            ALIGN: begin
                if (fall_tick) begin
                    state_d = PRE;
                    bit_d   = 6'd0;
                    oe_d    = 1'b1;
                    mdo_d   = 1'b1;
                end
            end
            PRE, HDR, TA, DAT: begin
                if (fall_tick) begin
                    if (bit_q == 6'd63) begin
                        state_d = FIN;
                        oe_d    = 1'b0;
                        if (!is_wr_q) rdata_d = shift_q;
                    end else begin
                        bit_d = nbit;
                        mdo_d = nbit[5] ? hdr_q[~nbit[4:0]] : 1'b1;
                        oe_d  = is_wr_q | (nbit < 6'd46);
                        if (nbit < 6'd32)      state_d = PRE;
                        else if (nbit < 6'd46) state_d = HDR;
                        else if (nbit < 6'd48) state_d = TA;
                        else                   state_d = DAT;
                    end
                end else if (rise_tick && !is_wr_q) begin
                    if (state_q == TA && bit_q == 6'd47) ta_bad_d = mdi;
                    if (state_q == DAT) shift_d = {shift_q[14:0], mdi};
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            mdc_q    <= 1'b0;
            bit_q    <= '0;
            is_wr_q  <= 1'b0;
            hdr_q    <= '0;
            oe_q     <= 1'b0;
            mdo_q    <= 1'b0;
            shift_q  <= '0;
            rdata_q  <= '0;
            ta_bad_q <= 1'b0;
            sync_q   <= 2'b11;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            mdc_q    <= mdc_d;
            bit_q    <= bit_d;
            is_wr_q  <= is_wr_d;
            hdr_q    <= hdr_d;
            oe_q     <= oe_d;
            mdo_q    <= mdo_d;
            shift_q  <= shift_d;
            rdata_q  <= rdata_d;
            ta_bad_q <= ta_bad_d;
            sync_q   <= sync_d;
        end
    end

endmodule

// File: tb/tb_smi_mdio_master.sv
// Bench for smi_mdio_master: vector table with a scoreboard of expected frames/results,
// plus hand-written reset-abort and mdc timing sequences.
module tb_smi_mdio_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc;
    wire         mdio;
    logic [4:0]  phy_addr = '0;
    logic [4:0]  reg_addr = '0;
    logic        write_req = 1'b0;
    logic [15:0] write_data = '0;
    logic        read_req = 1'b0;
    logic [15:0] read_data;
    logic        data_valid, done, busy, ta_err;

    logic phy_en = 1'b0;
    logic phy_val = 1'b1;
    assign mdio = phy_en ? phy_val : 1'bz;
    pullup (mdio);

    smi_mdio_master dut (
        .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio(mdio),
        .phy_addr(phy_addr), .reg_addr(reg_addr),
        .write_req(write_req), .write_data(write_data), .read_req(read_req),
        .read_data(read_data), .data_valid(data_valid), .done(done),
        .busy(busy), .ta_err(ta_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_wr;
        logic        both;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wdata;
        logic        phy_on;
        logic [15:0] rdata;
    } vec_t;

    typedef struct {
        logic [63:0] frame;
        logic [15:0] rdata;
        logic        ta_err;
        logic        dv;
    } exp_t;

    exp_t        sbq[$];
    vec_t        vecs[7];
    int          n_pass = 0;
    int          n_tot = 0;
    logic [15:0] last_rd = 16'h0000;

    logic    mon_en = 1'b0;
    longint  t_fall = 0;
    int      viol = 0;
    int      n_chg = 0;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial forever begin
        @(negedge mdc);
        t_fall = $time;
    end

    initial forever begin
        longint t;
        @(mdio);
        if (mon_en) begin
            t = $time;
            #1;
            n_chg++;
            if (t - t_fall > 10) viol++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    function automatic exp_t make_exp(input vec_t v, input logic [15:0] lrd);
        exp_t e;
        logic [1:0]  ta;
        logic [15:0] d;
        if (v.is_wr)       begin ta = 2'b10; d = v.wdata;  end
        else if (v.phy_on) begin ta = 2'b00; d = v.rdata;  end
        else               begin ta = 2'b11; d = 16'hFFFF; end
        e.frame  = {32'hFFFF_FFFF, 2'b01, (v.is_wr ? 2'b01 : 2'b10), v.phy, v.rg, ta, d};
        e.rdata  = v.is_wr ? lrd : d;
        e.ta_err = !v.is_wr && !v.phy_on;
        e.dv     = !v.is_wr;
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t        e;
        logic [63:0] cap = '0;
        logic        got = 1'b0;
        logic        dv_s = 1'b0, ta_s = 1'b0, busy_s = 1'b0, busy_after = 1'b1;
        logic [15:0] rd_s = '0;
        int          extra = 0;
        e = make_exp(v, last_rd);
        sbq.push_back(e);
        if (!v.is_wr) last_rd = e.rdata;
        mon_en = v.is_wr;
        @(negedge clk);
        phy_addr   = v.phy;
        reg_addr   = v.rg;
        write_data = v.wdata;
        write_req  = v.is_wr;
        read_req   = !v.is_wr || v.both;
        @(negedge clk);
        write_req  = 1'b0;
        read_req   = 1'b0;
        phy_addr   = ~v.phy;
        reg_addr   = ~v.rg;
        write_data = ~v.wdata;
        fork
            begin
                for (int k = 0; k < 64; k++) begin
                    @(negedge mdc);
                    #1;
                    if (!v.is_wr && v.phy_on && k >= 46) begin
                        phy_en  = 1'b1;
                        phy_val = (k < 48) ? 1'b0 : v.rdata[63-k];
                    end
                    if (k == 20) begin
                        write_req = 1'b1;
                        read_req  = 1'b1;
                        @(negedge clk);
                        write_req = 1'b0;
                        read_req  = 1'b0;
                    end
                    @(posedge mdc);
                    #1;
                    cap[63-k] = mdio;
                end
                @(negedge mdc);
                #1;
                phy_en = 1'b0;
            end
            begin
                for (int c = 0; c < 8000 && !got; c++) begin
                    @(negedge clk);
                    if (done) begin
                        got    = 1'b1;
                        dv_s   = data_valid;
                        ta_s   = ta_err;
                        rd_s   = read_data;
                        busy_s = busy;
                    end
                end
                if (got) begin
                    @(negedge clk);
                    busy_after = busy;
                    for (int c = 0; c < 200; c++) begin
                        @(negedge clk);
                        if (done) extra++;
                    end
                end
            end
        join
        mon_en = 1'b0;
        e = sbq.pop_front();
        chk("done_seen", 64'(got), 64'd1);
        chk("frame_bits", cap, e.frame);
        chk("read_data", 64'(rd_s), 64'(e.rdata));
        chk("ta_err", 64'(ta_s), 64'(e.ta_err));
        chk("data_valid", 64'(dv_s), 64'(e.dv));
        chk("busy_at_done", 64'(busy_s), 64'd1);
        chk("busy_after_done", 64'(busy_after), 64'd0);
        chk("extra_done", 64'(extra), 64'd0);
    endtask

    initial begin
        vec_t   pv;
        int     bad;
        longint t0, t1, t2;

        vecs[0] = '{1'b1, 1'b0, 5'd1,  5'd0,  16'h1140, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 5'd1,  5'd1,  16'h0000, 1'b1, 16'h796D};
        vecs[2] = '{1'b0, 1'b0, 5'd2,  5'd3,  16'h0000, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 1'b1, 5'd3,  5'd4,  16'hA5A5, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 5'd31, 5'd31, 16'h0000, 1'b1, 16'h0001};
        vecs[5] = '{1'b1, 1'b0, 5'd0,  5'd31, 16'h0000, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 1'b0, 5'd5,  5'd17, 16'h0000, 1'b1, 16'h8000};

        #23;
        chk("rst_mdc", 64'(mdc), 64'd0);
        chk("rst_mdio_released", 64'(mdio), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dv", 64'(data_valid), 64'd0);
        chk("rst_ta_err", 64'(ta_err), 64'd0);
        chk("rst_read_data", 64'(read_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        chk("mdio_change_after_fall", 64'(viol), 64'd0);
        chk("mdio_changes_seen", 64'(n_chg > 0), 64'd1);

        // Abort a write mid-frame with an asynchronous reset during bit 40 (mdc high).
        @(negedge clk);
        phy_addr = 5'd6; reg_addr = 5'd9; write_data = 16'h1234; write_req = 1'b1;
        @(negedge clk);
        write_req = 1'b0;
        repeat (41) @(negedge mdc);
        @(posedge mdc);
        #203;
        rst_n = 1'b0;
        #1;
        chk("arst_mdc_low", 64'(mdc), 64'd0);
        chk("arst_mdio_released", 64'(mdio), 64'd1);
        chk("arst_busy", 64'(busy), 64'd0);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        chk("arst_no_done_busy", 64'(bad), 64'd0);
        chk("arst_read_data", 64'(read_data), 64'd0);
        phy_en = 1'b1; phy_val = 1'b0;
        #3;
        chk("arst_idle_not_driving", 64'(mdio), 64'd0);
        phy_en = 1'b0;
        last_rd = 16'h0000;
        pv = '{1'b0, 1'b0, 5'd1, 5'd2, 16'h0000, 1'b1, 16'h5A3C};
        run_vec(pv);

        @(posedge mdc); t0 = $time;
        @(negedge mdc); t1 = $time;
        @(posedge mdc); t2 = $time;
        chk("mdc_period", 64'(t2 - t0), 64'd1000);
        chk("mdc_high", 64'(t1 - t0), 64'd500);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
